dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-ported data RAM.
- Port 0 is the core load/store path from the MEM stage. Port 1 is the debug/program-loader path.
- Grants one transaction at a time, round-robin, and drives the RAM command for one cycle.
- Checks size alignment and address range before issuing, then returns a read-data or write-ack response with a fixed latency.

---
 rtl/dmem_arbiter_pkg.sv | 42 ++++
 rtl/dmem_rr_arb.sv | 21 ++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: access sizes, RAM write sizes,
// port ids and FSM states.
package dmem_arbiter_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] WS_NONE = 3'd0;
  localparam logic [2:0] WS_B    = 3'd1;
  localparam logic [2:0] WS_H    = 3'd2;
  localparam logic [2:0] WS_W    = 3'd4;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  function automatic logic [2:0] size_to_wsize(input logic [1:0] size);
    case (size)
      SZ_B:    size_to_wsize = WS_B;
      SZ_H:    size_to_wsize = WS_H;
      SZ_W:    size_to_wsize = WS_W;
      default: size_to_wsize = WS_NONE;
    endcase
  endfunction

  // Illegal size counts as misaligned so one test covers both.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lsb[0];
      SZ_W:    misaligned = |lsb;
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, on contention the port
// that did not win last time wins.
module dmem_rr_arb
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       rr_last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (rr_last_i == PORT_CORE) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter and sequencer for the single-ported data RAM: one
// transaction at a time, strobe one cycle after accept, response one after that.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MEM_BASE  = 32'h0001_0000,
  parameter int unsigned     MEM_DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_we,
  input  logic [XLEN-1:0] req_addr0,
  input  logic [XLEN-1:0] req_addr1,
  input  logic [XLEN-1:0] req_wdata0,
  input  logic [XLEN-1:0] req_wdata1,
  input  logic [1:0]      req_size0,
  input  logic [1:0]      req_size1,
  output logic [1:0]      resp_valid,
  output logic            resp_err,
  output logic [XLEN-1:0] resp_rdata,
  output logic            busy,
  output logic            ram_read_flag,
  output logic            ram_write_flag,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  output logic [2:0]      ram_wsize,
  input  logic [XLEN-1:0] ram_rdata
);

  localparam logic [XLEN:0] MemLo = {1'b0, MEM_BASE};
  localparam logic [XLEN:0] MemHi = MemLo + (XLEN+1)'(4 * MEM_DEPTH);

  state_e          state_q, state_d;
  logic            rr_last_q;
  logic            cmd_port_q;
  logic            cmd_we_q;
  logic            cmd_err_q;
  logic [1:0]      cmd_size_q;
  logic [XLEN-1:0] cmd_addr_q;
  logic [XLEN-1:0] cmd_wdata_q;

  logic [1:0]      gnt;
  logic            accept;
  logic            win_port;
  logic            win_we;
  logic [1:0]      win_size;
  logic [XLEN-1:0] win_addr;
  logic [XLEN-1:0] win_wdata;
  logic [XLEN:0]   win_addr_ext;
  logic            win_err;

  dmem_rr_arb u_rr_arb (
    .valid_i   (req_valid),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt)
  );

  assign accept       = rst && (state_q == StIdle) && (|gnt);
  assign win_port     = gnt[1] ? PORT_DBG : PORT_CORE;
  assign win_we       = req_we[win_port];
  assign win_addr     = win_port ? req_addr1  : req_addr0;
  assign win_wdata    = win_port ? req_wdata1 : req_wdata0;
  assign win_size     = win_port ? req_size1  : req_size0;
  assign win_addr_ext = {1'b0, win_addr};
  assign win_err      = misaligned(win_size, win_addr[1:0]) ||
                        (win_addr_ext < MemLo) || (win_addr_ext >= MemHi);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_last_q   <= PORT_DBG;
      cmd_port_q  <= PORT_CORE;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      cmd_size_q  <= SZ_B;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_last_q   <= win_port;
        cmd_port_q  <= win_port;
        cmd_we_q    <= win_we;
        cmd_err_q   <= win_err;
        cmd_size_q  <= win_size;
        cmd_addr_q  <= win_addr;
        cmd_wdata_q <= win_wdata;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready      = 2'b00;
    busy           = 1'b0;
    ram_read_flag  = 1'b0;
    ram_write_flag = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_wsize      = WS_NONE;
    resp_valid     = 2'b00;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = rst ? gnt : 2'b00;
        if (accept) state_d = StAccess;
      end
      StAccess: begin
        // Failing commands still spend this cycle here so response latency is fixed.
        busy    = 1'b1;
        state_d = StResp;
        if (!cmd_err_q) begin
          ram_addr = cmd_addr_q;
          if (cmd_we_q) begin
            ram_write_flag = 1'b1;
            ram_wdata      = cmd_wdata_q;
            ram_wsize      = size_to_wsize(cmd_size_q);
          end else begin
            ram_read_flag = 1'b1;
          end
        end
      end
      StResp: begin
        busy                   = 1'b1;
        resp_valid[cmd_port_q] = 1'b1;
        resp_err               = cmd_err_q;
        if (!cmd_we_q && !cmd_err_q) resp_rdata = ram_rdata;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural RAM behind it.
module tb_dmem_arbiter;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = 2'b00;
  logic [31:0] req_addr0 = '0, req_addr1 = '0;
  logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]  req_size0 = '0, req_size1 = '0;
  logic [1:0]  resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        busy;
  logic        ram_read_flag, ram_write_flag;
  logic [31:0] ram_addr, ram_wdata;
  logic [2:0]  ram_wsize;
  logic [31:0] ram_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  dmem_arbiter #(.XLEN(32), .MEM_BASE(BASE), .MEM_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .req_size0      (req_size0),
    .req_size1      (req_size1),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .busy           (busy),
    .ram_read_flag  (ram_read_flag),
    .ram_write_flag (ram_write_flag),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_wsize      (ram_wsize),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Little-endian RAM, reloaded with known contents while reset is held.
  logic [31:0] mem [DEPTH];
  logic [31:0] ram_off;
  assign ram_off = ram_addr - BASE;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
      mem[0]       <= 32'h1122_3344;
      mem[2]       <= 32'hDEAD_BEEF;
      mem[DEPTH-1] <= 32'hCAFE_F00D;
      ram_rdata    <= 32'h0;
    end else begin
      if (ram_read_flag) ram_rdata <= mem[ram_off[11:2]];
      if (ram_write_flag) begin
        case (ram_wsize)
          3'd1: mem[ram_off[11:2]][{ram_off[1:0], 3'b000} +: 8] <= ram_wdata[7:0];
          3'd2: mem[ram_off[11:2]][{ram_off[1], 4'b0000} +: 16] <= ram_wdata[15:0];
          3'd4: mem[ram_off[11:2]] <= ram_wdata;
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Presents one request and returns one cycle after the accepting edge (N+1).
  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size);
    bit got = 0;
    if (port == 0) begin
      req_addr0 = addr; req_wdata0 = wdata; req_size0 = size;
    end else begin
      req_addr1 = addr; req_wdata1 = wdata; req_size1 = size;
    end
    req_we[port]    = we;
    req_valid[port] = 1'b1;
    for (int w = 0; w < 8 && !got; w++) begin
      #1;
      if (req_ready[port]) got = 1;
      tick();
    end
    req_valid[port] = 1'b0;
    req_addr0 = 32'hFFFF_FFFF; req_addr1 = 32'hFFFF_FFFF;
    total_cnt++;
    if (!got) $display("FAIL accept_timeout port=%0d: not accepted within 8 cycles", port);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    #3;
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, busy, ram_read_flag, ram_write_flag, ram_wsize}
        !== 11'b0 || resp_rdata !== 32'h0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0)
      $display("FAIL reset_outputs: ready=%b rv=%b busy=%b rd=%b wr=%b addr=%h, want all 0",
               req_ready, resp_valid, busy, ram_read_flag, ram_write_flag, ram_addr);
    else pass_cnt++;
    req_valid = 2'b00;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_core_read();
    issue(0, 1'b0, BASE + 32'd8, 32'h0, 2'd2);
    total_cnt++;
    if (ram_read_flag !== 1'b1 || ram_write_flag !== 1'b0 || ram_addr !== BASE + 32'd8)
      $display("FAIL core_read_strobe: rd=%b wr=%b addr=%h, want 1 0 %h",
               ram_read_flag, ram_write_flag, ram_addr, BASE + 32'd8);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0)
      $display("FAIL core_read_resp: rv=%b rdata=%h err=%b, want 01 deadbeef 0",
               resp_valid, resp_rdata, resp_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_dbg_write();
    issue(1, 1'b1, BASE + 32'd3, 32'h0000_00A5, 2'd0);
    total_cnt++;
    if (ram_write_flag !== 1'b1 || ram_read_flag !== 1'b0 || ram_wsize !== 3'd1 ||
        ram_wdata !== 32'h0000_00A5 || ram_addr !== BASE + 32'd3)
      $display("FAIL dbg_write_strobe: wr=%b rd=%b ws=%0d wd=%h addr=%h, want 1 0 1 a5 %h",
               ram_write_flag, ram_read_flag, ram_wsize, ram_wdata, ram_addr, BASE + 32'd3);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (resp_valid !== 2'b10 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      $display("FAIL dbg_write_resp: rv=%b rdata=%h err=%b, want 10 0 0",
               resp_valid, resp_rdata, resp_err);
    else pass_cnt++;
    tick();
    issue(0, 1'b0, BASE, 32'h0, 2'd2);
    tick();
    total_cnt++;
    if (resp_valid !== 2'b01 || resp_rdata !== 32'hA522_3344)
      $display("FAIL readback_after_byte_write: rv=%b rdata=%h, want 01 a5223344",
               resp_valid, resp_rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5] = '{BASE + 32'd1, BASE + 32'd4096, BASE, BASE - 32'd4, BASE + 32'd4092};
    logic [1:0]  sizes [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    logic        wes   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        errs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] rdat  [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D};
    for (int i = 0; i < 5; i++) begin
      issue(i % 2, wes[i], addrs[i], 32'h1234_5678, sizes[i]);
      total_cnt++;
      if ((ram_read_flag | ram_write_flag) !== !errs[i])
        $display("FAIL err_strobe[%0d]: rd=%b wr=%b, want strobe=%b",
                 i, ram_read_flag, ram_write_flag, !errs[i]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (resp_err !== errs[i] || resp_valid !== ((i % 2) ? 2'b10 : 2'b01) ||
          resp_rdata !== rdat[i])
        $display("FAIL err_resp[%0d]: err=%b rv=%b rdata=%h, want err=%b rdata=%h",
                 i, resp_err, resp_valid, resp_rdata, errs[i], rdat[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int last_cyc = 0;
    do_reset();
    req_addr0 = BASE + 32'd8; req_addr1 = BASE;
    req_size0 = 2'd2;         req_size1 = 2'd2;
    req_we    = 2'b00;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bit got = 0;
      logic [1:0] seen = 2'b00;
      int acc_cyc = 0;
      for (int w = 0; w < 8 && !got; w++) begin
        #1;
        if (req_ready != 2'b00) begin
          got = 1; seen = req_ready; acc_cyc = cyc;
        end
        tick();
      end
      total_cnt++;
      if (!got || seen !== ((k % 2) ? 2'b10 : 2'b01))
        $display("FAIL rr_order[%0d]: ready=%b got=%0d, want %b", k, seen, got,
                 (k % 2) ? 2'b10 : 2'b01);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (acc_cyc - last_cyc != 3)
          $display("FAIL rr_spacing[%0d]: %0d cycles, want 3", k, acc_cyc - last_cyc);
        else pass_cnt++;
      end
      last_cyc = acc_cyc;
    end
    req_valid = 2'b00;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit stray = 0;
    issue(0, 1'b0, BASE + 32'd8, 32'h0, 2'd2);
    total_cnt++;
    if (ram_read_flag !== 1'b1)
      $display("FAIL mid_reset_access: rd=%b, want 1", ram_read_flag);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, busy, ram_read_flag, ram_write_flag} !== 8'b0 ||
        ram_addr !== 32'h0)
      $display("FAIL mid_reset_outputs: rd=%b busy=%b addr=%h rv=%b, want all 0",
               ram_read_flag, busy, ram_addr, resp_valid);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 2'b00 || busy !== 1'b0) stray = 1;
      tick();
    end
    total_cnt++;
    if (stray) $display("FAIL mid_reset_no_resp: response or busy seen after release");
    else pass_cnt++;
    req_addr0 = BASE; req_addr1 = BASE; req_we = 2'b00;
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL mid_reset_first_grant: ready=%b, want 01", req_ready);
    else pass_cnt++;
    tick();
    req_valid = 2'b00;
    total_cnt++;
    if (ram_read_flag !== 1'b1 || ram_addr !== BASE)
      $display("FAIL mid_reset_next_access: rd=%b addr=%h, want 1 %h",
               ram_read_flag, ram_addr, BASE);
    else pass_cnt++;
    tick();
    tick();
  endtask

  initial begin
    do_reset();
    test_reset();
    test_core_read();
    test_dbg_write();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
